// File: rtl/chip8_alu_seq_if.sv
// Launch/result bus between the CPU datapath (master) and the sequential ALU (slave).
interface chip8_alu_seq_if #(
   parameter int WIDTH      = 8,
   parameter int BCD_DIGITS = 3
) ();
   logic                    start;
   logic [3:0]              op;
   logic [WIDTH-1:0]        in_a;
   logic [WIDTH-1:0]        in_b;
   logic                    busy;
   logic                    done;
   logic [WIDTH-1:0]        result;
   logic                    carry;
   logic [4*BCD_DIGITS-1:0] bcd;
   logic                    illegal;

   modport master (
      output start, op, in_a, in_b,
      input  busy, done, result, carry, bcd, illegal
   );

   modport slave (
      input  start, op, in_a, in_b,
      output busy, done, result, carry, bcd, illegal
   );
endinterface

// File: rtl/chip8_alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shifts with last-bit-out carry,
// and iterative double-dabble binary-to-BCD conversion.
module chip8_alu_seq #(
   parameter int WIDTH      = 8,
   parameter int BCD_DIGITS = 3
) (
   input logic            clk,
   input logic            reset,
   chip8_alu_seq_if.slave bus
);
   localparam int BW    = 4 * BCD_DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

   localparam logic [3:0] OP_OR   = 4'd0;
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_SUBN = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_EQ   = 4'd8;
   localparam logic [3:0] OP_GT   = 4'd9;
   localparam logic [3:0] OP_INC  = 4'd10;
   localparam logic [3:0] OP_BCD  = 4'd11;

   typedef enum logic [1:0] {IDLE, SHIFT, CONV} state_t;

   // Returns {bit shifted out, shifted value}.
   function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] v, input logic left);
      if (left) return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      else      return {v[0], 1'b0, v[WIDTH-1:1]};
   endfunction

   // One double-dabble iteration: add 3 to every digit >= 5, then shift {acc, sh} left.
   function automatic logic [BW+WIDTH-1:0] dabble(input logic [BW-1:0] acc,
                                                  input logic [WIDTH-1:0] sh);
      logic [BW-1:0] adj;
      adj = acc;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      return {adj[BW-2:0], sh, 1'b0};
   endfunction

   state_t              state;
   logic [WIDTH-1:0]    work;
   logic [WIDTH-1:0]    a_lat;
   logic [BW-1:0]       bcd_acc;
   logic [CNT_W-1:0]    cnt;
   logic                left;

   logic [WIDTH-1:0]    n_clamp;
   logic [WIDTH:0]      shift_in;
   logic [WIDTH:0]      shift_work;
   logic [BW+WIDTH-1:0] dab_in;
   logic [BW+WIDTH-1:0] dab_work;
   logic [WIDTH:0]      sum;

   always_comb begin
      n_clamp    = (bus.in_b > WIDTH_V) ? WIDTH_V : bus.in_b;
      shift_in   = shift1(bus.in_a, bus.op == OP_SHL);
      shift_work = shift1(work, left);
      dab_in     = dabble('0, bus.in_a);
      dab_work   = dabble(bcd_acc, work);
      sum        = {1'b0, bus.in_a} + {1'b0, bus.in_b};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.illegal <= 1'b0;
         bus.result  <= '0;
         bus.carry   <= 1'b0;
         bus.bcd     <= '0;
      end else begin
         bus.done    <= 1'b0;
         bus.illegal <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.done  <= 1'b1;
                  bus.carry <= 1'b0;
                  case (bus.op)
                     OP_OR:   bus.result <= bus.in_a | bus.in_b;
                     OP_AND:  bus.result <= bus.in_a & bus.in_b;
                     OP_XOR:  bus.result <= bus.in_a ^ bus.in_b;
                     OP_ADD:  {bus.carry, bus.result} <= sum;
                     OP_SUB: begin
                        bus.result <= bus.in_a - bus.in_b;
                        bus.carry  <= (bus.in_a >= bus.in_b);
                     end
                     OP_SUBN: begin
                        bus.result <= bus.in_b - bus.in_a;
                        bus.carry  <= (bus.in_b >= bus.in_a);
                     end
                     OP_SHR, OP_SHL: begin
                        if (n_clamp == '0) begin
                           bus.result <= bus.in_a;
                        end else if (n_clamp == WIDTH'(1)) begin
                           bus.result <= shift_in[WIDTH-1:0];
                           bus.carry  <= shift_in[WIDTH];
                        end else begin
                           // First bit is shifted on accept so done lands n cycles later.
                           bus.done   <= 1'b0;
                           bus.carry  <= bus.carry;
                           bus.busy   <= 1'b1;
                           work       <= shift_in[WIDTH-1:0];
                           left       <= (bus.op == OP_SHL);
                           cnt        <= CNT_W'(n_clamp - WIDTH'(1));
                           state      <= SHIFT;
                        end
                     end
                     OP_EQ:   bus.result <= {{(WIDTH-1){1'b0}}, bus.in_a == bus.in_b};
                     OP_GT:   bus.result <= {{(WIDTH-1){1'b0}}, bus.in_a > bus.in_b};
                     OP_INC:  bus.result <= bus.in_a + WIDTH'(1);
                     OP_BCD: begin
                        bus.done  <= 1'b0;
                        bus.carry <= bus.carry;
                        bus.busy  <= 1'b1;
                        a_lat     <= bus.in_a;
                        bcd_acc   <= dab_in[BW+WIDTH-1:WIDTH];
                        work      <= dab_in[WIDTH-1:0];
                        cnt       <= CNT_W'(WIDTH - 1);
                        state     <= CONV;
                     end
                     default: begin
                        bus.result  <= '0;
                        bus.illegal <= 1'b1;
                     end
                  endcase
               end
            end
            SHIFT: begin
               work <= shift_work[WIDTH-1:0];
               cnt  <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  bus.result <= shift_work[WIDTH-1:0];
                  bus.carry  <= shift_work[WIDTH];
                  bus.done   <= 1'b1;
                  bus.busy   <= 1'b0;
                  state      <= IDLE;
               end
            end
            CONV: begin
               bcd_acc <= dab_work[BW+WIDTH-1:WIDTH];
               work    <= dab_work[WIDTH-1:0];
               cnt     <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  bus.bcd    <= dab_work[BW+WIDTH-1:WIDTH];
                  bus.result <= a_lat;
                  bus.carry  <= 1'b0;
                  bus.done   <= 1'b1;
                  bus.busy   <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule
